// File: rtl/spi_slave_unit.sv
// spi_slave_unit
//   Byte-oriented SPI slave (mode-0 style, MSB first). It runs entirely in
//   the SPI serial clock domain. While ss is low, a byte is shifted in on
//   mosi and presented on data_out with a one-cycle data_rdy strobe. In the
//   same bits, the byte previously latched from data_in is shifted out on
//   miso.
//
// Ports
//   clk        in   SPI serial clock; all state updates on the rising edge
//   rst        in   synchronous active-low reset
//   ss         in   slave select, active-low (1 = idle)
//   mosi       in   serial data from master
//   miso       out  serial data to master (registered, always driven)
//   data_in    in   [7:0] transmit byte from local logic
//   data_latch in   capture data_in into the transmit buffer at this edge
//   data_out   out  [7:0] last complete received byte
//   data_rdy   out  one-cycle pulse when data_out updates
module spi_slave_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] data_in,
  input  logic       data_latch,
  output logic [7:0] data_out,
  output logic       data_rdy
);

  logic [7:0] tx_buf;
  logic [7:0] tx_sh;
  logic [6:0] rx_sh;
  logic [2:0] cnt;
  logic [7:0] nxt;

  // Bypass so that a latch in the same cycle as a reload is honoured.
  assign nxt = data_latch ? data_in : tx_buf;

  // miso is always loaded with the same value as tx_sh[7] (nxt[7] on a
  // reload, tx_sh[6] on a shift), so the flop is shared with tx_sh.
  assign miso = tx_sh[7];

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_buf   <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      cnt      <= '0;
      data_out <= '0;
      data_rdy <= 1'b0;
    end else begin
      if (data_latch) begin
        tx_buf <= data_in;
      end

      if (ss) begin
        // Idle: a partial byte is dropped without a strobe.
        cnt      <= '0;
        tx_sh    <= nxt;
        data_rdy <= 1'b0;
      end else begin
        rx_sh <= {rx_sh[5:0], mosi};
        cnt   <= cnt + 3'd1;
        if (cnt != 3'd7) begin
          tx_sh    <= {tx_sh[6:0], 1'b0};
          data_rdy <= 1'b0;
        end else begin
          // Byte boundary: deliver the received byte and reload the transmitter.
          data_out <= {rx_sh, mosi};
          data_rdy <= 1'b1;
          tx_sh    <= nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_unit.sv
// tb_spi_slave_unit
//   Directed bench for spi_slave_unit. The bench acts as the SPI master and
//   as the local logic around the slave.
module tb_spi_slave_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss;
  logic       mosi;
  logic       miso;
  logic [7:0] data_in;
  logic       data_latch;
  logic [7:0] data_out;
  logic       data_rdy;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] cap;
  logic [7:0] cap_lo;
  int         pulses;

  always #5 clk = ~clk;

  spi_slave_unit dut (
    .clk        (clk),
    .rst        (rst),
    .ss         (ss),
    .mosi       (mosi),
    .miso       (miso),
    .data_in    (data_in),
    .data_latch (data_latch),
    .data_out   (data_out),
    .data_rdy   (data_rdy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One 8-edge byte with ss low. The master drives mosi from m_byte and
  // captures miso just before each edge. latch_at = 1..8 pulses data_latch
  // with lval during that edge (0 = no latch).
  task automatic xfer(input logic [7:0] m_byte, input int latch_at, input logic [7:0] lval,
                      output logic [7:0] c, output int p);
    c = '0;
    p = 0;
    ss = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mosi       = m_byte[7-i];
      c          = {c[6:0], miso};
      data_latch = (i + 1 == latch_at);
      data_in    = lval;
      tick();
      if (data_rdy) p++;
    end
    data_latch = 1'b0;
  endtask

  initial begin
    // Reset, with a latch request that reset must override.
    rst = 1'b0; ss = 1'b1; mosi = 1'b0; data_latch = 1'b1; data_in = 8'hFF;
    tick();
    tick();
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_data_rdy", {7'd0, data_rdy}, 8'h00);
    chk("rst_miso", {7'd0, miso}, 8'h00);
    data_latch = 1'b0; rst = 1'b1;
    tick();
    chk("idle_miso_after_rst", {7'd0, miso}, 8'h00);

    // Single receive 0x5B.
    xfer(8'h5B, 0, 8'h00, cap, pulses);
    chk("rx_data_out", data_out, 8'h5B);
    chk("rx_data_rdy", {7'd0, data_rdy}, 8'h01);
    chk("rx_pulses", 8'(pulses), 8'd1);
    chk("rx_tx_zero", cap, 8'h00);
    ss = 1'b1;
    tick();
    chk("rx_rdy_drop", {7'd0, data_rdy}, 8'h00);
    chk("rx_hold", data_out, 8'h5B);

    // Transmit 0xA6 latched while idle.
    data_in = 8'hA6; data_latch = 1'b1;
    tick();
    data_latch = 1'b0;
    chk("tx_idle_miso", {7'd0, miso}, 8'h01);
    xfer(8'h00, 0, 8'h00, cap, pulses);
    chk("tx_capture", cap, 8'hA6);
    chk("tx_rx_zero", data_out, 8'h00);
    ss = 1'b1;
    tick();

    // Loopback ring: master 0x5B, slave 0x3C.
    data_in = 8'h3C; data_latch = 1'b1;
    tick();
    data_latch = 1'b0;
    chk("loop_idle_miso", {7'd0, miso}, 8'h00);
    xfer(8'h5B, 0, 8'h00, cap, pulses);
    chk("loop_data_out", data_out, 8'h5B);
    chk("loop_master", cap, 8'h3C);
    ss = 1'b1;
    tick();

    // Back-to-back 0x12 then 0x34, latching 0x77 at the 8th edge.
    xfer(8'h12, 8, 8'h77, cap, pulses);
    chk("b2b_out1", data_out, 8'h12);
    chk("b2b_rdy1", {7'd0, data_rdy}, 8'h01);
    chk("b2b_pulses1", 8'(pulses), 8'd1);
    chk("b2b_tx1", cap, 8'h3C);
    xfer(8'h34, 0, 8'h00, cap, pulses);
    chk("b2b_out2", data_out, 8'h34);
    chk("b2b_rdy2", {7'd0, data_rdy}, 8'h01);
    chk("b2b_pulses2", 8'(pulses), 8'd1);
    chk("b2b_tx2", cap, 8'h77);
    ss = 1'b1;
    tick();
    chk("b2b_idle_rdy", {7'd0, data_rdy}, 8'h00);

    // Abort after 5 edges, then a full 0xC3 with a mid-byte latch of 0xFF.
    ss = 1'b0; mosi = 1'b1; pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (data_rdy) pulses++;
    end
    ss = 1'b1;
    tick();
    chk("abort_pulses", 8'(pulses), 8'd0);
    chk("abort_rdy", {7'd0, data_rdy}, 8'h00);
    chk("abort_hold", data_out, 8'h34);
    xfer(8'hC3, 4, 8'hFF, cap, pulses);
    chk("after_abort_out", data_out, 8'hC3);
    chk("after_abort_pulses", 8'(pulses), 8'd1);
    chk("midlatch_inflight", cap, 8'h77);
    ss = 1'b1;
    tick();
    chk("midlatch_next_miso", {7'd0, miso}, 8'h01);

    // Reset mid-byte discards the partial byte and clears the buffer.
    ss = 1'b0; mosi = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_data_out", data_out, 8'h00);
    chk("midrst_miso", {7'd0, miso}, 8'h00);
    chk("midrst_rdy", {7'd0, data_rdy}, 8'h00);
    rst = 1'b1; ss = 1'b1;
    tick();
    xfer(8'hA5, 0, 8'h00, cap, pulses);
    cap_lo = cap;
    chk("postrst_out", data_out, 8'hA5);
    chk("postrst_tx", cap_lo, 8'h00);
    chk("postrst_pulses", 8'(pulses), 8'd1);
    ss = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
